dobbelsteen_s00_axi_regs: RTL
=============================

DOBBELSTEEN_S00_AXI_REGS -- requirements
Module: dobbelsteen_s00_axi_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-002 ROLL_CYCLES, 16, number of face updates per roll (range 1..255).
REQ-003 s00_axi_aclk  in  1  single clock; all logic rising-edge.
REQ-004 s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s00_axi_awaddr  in  4  write address; byte address, bits[3:2] decoded.
REQ-006 s00_axi_awvalid  in  1  write address valid.
REQ-007 s00_axi_awready  out  1  write address accepted.
REQ-008 s00_axi_wdata  in  32  write data.
REQ-009 s00_axi_wstrb  in  4  byte write enables.
REQ-010 s00_axi_wvalid  in  1  write data valid.
REQ-011 s00_axi_wready  out  1  write data accepted.
REQ-012 s00_axi_bresp  out  2  write response; always 2'b00 (OKAY).
REQ-013 s00_axi_bvalid  out  1  write response valid.
REQ-014 s00_axi_bready  in  1  write response accepted by master.
REQ-015 s00_axi_araddr  in  4  read address; bits[3:2] decoded.
REQ-016 s00_axi_arvalid  in  1  read address valid.
REQ-017 s00_axi_arready  out  1  read address accepted.
REQ-018 s00_axi_rdata  out  32  read data.
REQ-019 s00_axi_rresp  out  2  read response; always 2'b00.
REQ-020 s00_axi_rvalid  out  1  read data valid.
REQ-021 s00_axi_rready  in  1  read data accepted by master.
REQ-022 dice_face  out  3  current die face, 0 = none, 1..6 valid.
REQ-023 roll_busy  out  1  high while a roll is in progress.

Function
REQ-024 Write channel: awready and wready pulse high together for exactly one cycle once awvalid and wvalid are both high and bvalid is low; AW/W arrival order is free; the register write occurs in that same cycle.
REQ-025 bvalid rises the cycle after the write and holds until bready is sampled high; no new write is accepted while bvalid is high.
REQ-026 Read channel: arready pulses one cycle when arvalid is high and rvalid is low; rdata is registered and rvalid rises next cycle, both held until rready is sampled high.
REQ-027 Simultaneous read and write are independent; a read in the write cycle returns the pre-write value.
REQ-028 Register map: 0x0 CTRL (bit0 ROLL write-1-to-start, reads 0; bit1 AUTO, RW); 0x4 RESULT RO ({23'b0, valid bit8, 5'b0, face[2:0]}); 0x8 SEED RW [15:0]; 0xC COUNT RO [15:0], any write clears it to 0.
REQ-029 wstrb applies per byte to RW fields; writes to RESULT are ignored with OKAY response.
REQ-030 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle; a SEED write loads the LFSR next cycle, with 0 replaced by 16'hACE1.
REQ-031 FSM IDLE -> ROLLING on ROLL write, or in IDLE when AUTO=1; valid clears on entry, roll_busy=1.
REQ-032 ROLLING: each cycle LFSR[2:0] in 1..6 is loaded to dice_face and the step counter increments; values 0 and 7 are rejected with no count; at ROLL_CYCLES steps -> DONE.
REQ-033 DONE (one cycle): valid=1, COUNT increments (wraps 0xFFFF -> 0), roll_busy=0, -> IDLE.
REQ-034 A ROLL write during ROLLING is ignored; a COUNT clear coincident with DONE yields COUNT=0.

Reset
REQ-035 Reset: all ready/valid outputs and rdata/bresp/rresp = 0, CTRL/SEED/COUNT = 0, LFSR = 16'hACE1, FSM IDLE, dice_face = 0, roll_busy = 0; reset mid-roll or mid-handshake aborts immediately.

Configuration
REQ-036 DOBBELSTEEN_IRQ_EN defined: adds output port irq (1 bit) and CTRL bit2 IRQ_PEND (set in DONE, write-1-clears, sets win over clears); irq = IRQ_PEND & CTRL bit3 IRQ_MASK(RW). Undefined: no irq port, and CTRL bits 3:2 read 0, writes ignored.

Verification
REQ-037 Write 0x8=0x0000 then read 0x8 -> 0x00000000; LFSR reloads 0xACE1; a roll yields the same face sequence as after reset.
REQ-038 Write 0x0=0x1, poll 0x4 -> bit8=1 with face 1..6 after >=ROLL_CYCLES+1 cycles; 0xC reads 1.
REQ-039 AW 3 cycles before W, bready held low 5 cycles -> single write, bvalid held 5 cycles, no second acceptance.
REQ-040 Write 0x0=0x2 for 3 rolls, write 0x0=0x0, write 0xC=0 -> COUNT reads 0; 0x0 reads 0x0.
REQ-041 Assert s00_axi_aresetn low mid-roll -> roll_busy=0, dice_face=0 asynchronously; 0x4 reads 0.
REQ-042 With DOBBELSTEEN_IRQ_EN: set IRQ_MASK, roll -> irq=1 after DONE; write 0x0=0xC -> irq=0.

Source files
------------

// File: rtl/dobbelsteen_s00_axi_regs.sv
// ---------------------------------------------------------------------------
// dobbelsteen_s00_axi_regs
// AXI4-Lite slave register block for an electronic die.
//   0x0 CTRL   : bit0 ROLL (write 1 to start, reads 0), bit1 AUTO (RW)
//   0x4 RESULT : {23'b0, valid, 5'b0, face[2:0]} read-only
//   0x8 SEED   : [15:0] RW, any write reloads the LFSR (0 -> 16'hACE1)
//   0xC COUNT  : [15:0] completed rolls, any write clears it
// A free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) feeds the die.
// A roll samples LFSR[2:0] every cycle, keeps values 1..6 and ends after
// ROLL_CYCLES accepted samples.
//
// Optional feature macro: DOBBELSTEEN_IRQ_EN
//   Defined  : adds output irq, CTRL bit2 IRQ_PEND (W1C, set on roll done,
//              set wins over clear) and CTRL bit3 IRQ_MASK (RW);
//              irq = IRQ_PEND & IRQ_MASK.
//   Undefined: no irq port, CTRL bits 3:2 read 0 and ignore writes.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised by this block, holds until that edge.
// ---------------------------------------------------------------------------
module dobbelsteen_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ROLL_CYCLES        = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [3:0]                      s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [3:0]                      s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
`ifdef DOBBELSTEEN_IRQ_EN
  output logic                            irq,
`endif
  output logic [2:0]                      dice_face,
  output logic                            roll_busy
);

  localparam logic [1:0]  LP_ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  LP_ADDR_RESULT = 2'd1;
  localparam logic [1:0]  LP_ADDR_SEED   = 2'd2;
  localparam logic [1:0]  LP_ADDR_COUNT  = 2'd3;
  localparam logic [15:0] LP_LFSR_INIT   = 16'hACE1;
  localparam logic [7:0]  LP_LAST_STEP   = 8'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bus channel state
  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  // Register file
  logic        r_auto;
  logic [15:0] r_seed;
  logic [15:0] r_count;
  logic [15:0] r_lfsr;

  // Roll engine
  state_t      r_state;
  logic [7:0]  r_steps;
  logic [2:0]  r_face;
  logic        r_busy;
  logic        r_valid;

  // Decoded write strobes
  logic                          w_wr_en;
  logic                          w_rd_en;
  logic [1:0]                    w_wr_sel;
  logic                          w_ctrl_wr;
  logic                          w_seed_wr;
  logic                          w_count_wr;
  logic                          w_roll_wr;
  logic [15:0]                   w_seed_next;
  logic                          w_lfsr_fb;
  logic                          w_lfsr_ok;
  logic [1:0]                    w_ctrl_hi;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
  logic                          w_unused_ok;

  // A write lands on the edge where the single-cycle ready pulse meets both valids.
  assign w_wr_en    = r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_en    = r_arready & s00_axi_arvalid;
  assign w_wr_sel   = s00_axi_awaddr[3:2];
  assign w_ctrl_wr  = w_wr_en & (w_wr_sel == LP_ADDR_CTRL) & s00_axi_wstrb[0];
  assign w_seed_wr  = w_wr_en & (w_wr_sel == LP_ADDR_SEED);
  assign w_count_wr = w_wr_en & (w_wr_sel == LP_ADDR_COUNT);
  assign w_roll_wr  = w_ctrl_wr & s00_axi_wdata[0];

  // Byte-merged seed value as it will look after this write.
  assign w_seed_next[7:0]  = s00_axi_wstrb[0] ? s00_axi_wdata[7:0]  : r_seed[7:0];
  assign w_seed_next[15:8] = s00_axi_wstrb[1] ? s00_axi_wdata[15:8] : r_seed[15:8];

  // Feedback taps 16,14,13,11 map to bits 15,13,12,10; shift toward the MSB.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_ok = (r_lfsr[2:0] != 3'd0) && (r_lfsr[2:0] != 3'd7);

  // Bits of the bus inputs that carry no meaning in this register map.
  assign w_unused_ok = &{1'b0, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:16], s00_axi_wstrb[3:2]};

  // Write address/data accept pulse and write response
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= ~r_awready & s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
      end else if (s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read address accept pulse and registered read data
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & s00_axi_arvalid & ~r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

`ifdef DOBBELSTEEN_IRQ_EN
  logic r_irq_mask;
  logic r_irq_pend;

  assign w_ctrl_hi = {r_irq_mask, r_irq_pend};
  assign irq       = r_irq_pend & r_irq_mask;

  // Interrupt mask (RW) and pending flag (set on roll done, write-1-clears)
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_irq_mask <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_mask <= s00_axi_wdata[3];
      end
      if (r_state == ST_DONE) begin
        r_irq_pend <= 1'b1;
      end else if (w_ctrl_wr && s00_axi_wdata[2]) begin
        r_irq_pend <= 1'b0;
      end
    end
  end
`else
  assign w_ctrl_hi = 2'b00;
`endif

  // Read mux; sampled into r_rdata so a same-cycle write is not visible
  always_comb begin
    w_rd_data = '0;
    case (s00_axi_araddr[3:2])
      LP_ADDR_CTRL:   w_rd_data = {28'd0, w_ctrl_hi, r_auto, 1'b0};
      LP_ADDR_RESULT: w_rd_data = {23'd0, r_valid, 5'd0, r_face};
      LP_ADDR_SEED:   w_rd_data = {16'd0, r_seed};
      LP_ADDR_COUNT:  w_rd_data = {16'd0, r_count};
      default:        w_rd_data = '0;
    endcase
  end

  // CTRL.AUTO, SEED and the free-running LFSR (a seed write reloads it)
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_auto <= 1'b0;
      r_seed <= 16'd0;
      r_lfsr <= LP_LFSR_INIT;
    end else begin
      if (w_ctrl_wr) begin
        r_auto <= s00_axi_wdata[1];
      end
      if (w_seed_wr) begin
        r_seed <= w_seed_next;
        r_lfsr <= (w_seed_next == 16'd0) ? LP_LFSR_INIT : w_seed_next;
      end else begin
        r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
    end
  end

  // Roll sequencer: IDLE -> ROLLING -> DONE (one cycle) -> IDLE
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state <= ST_IDLE;
      r_steps <= 8'd0;
      r_face  <= 3'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_roll_wr || r_auto) begin
            r_state <= ST_ROLLING;
            r_steps <= 8'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_ROLLING: begin
          // Only faces 1..6 count as a step; 0 and 7 are skipped.
          if (w_lfsr_ok) begin
            r_face <= r_lfsr[2:0];
            if (r_steps == LP_LAST_STEP) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_steps <= r_steps + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Completed-roll counter; a clear on the DONE edge wins
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_count <= 16'd0;
    end else if (w_count_wr) begin
      r_count <= 16'd0;
    end else if (r_state == ST_DONE) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign dice_face       = r_face;
  assign roll_busy       = r_busy;

endmodule
